heap_pqueue: RTL and testbench

HEAP_PQUEUE -- requirements
Module: heap_pqueue

---
 rtl/heap_pkg.sv | 20 ++
 rtl/heap_cmp3.sv | 45 ++++
 rtl/heap_pqueue.sv | 195 +++++++++++++++++++
 tb/tb_heap_pqueue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// heap_pkg -- shared types and constants for the heap priority queue.
//   state_t : sift-engine states (IDLE, UP, DOWN)
//   OP_*    : command encodings for in_op
//   SEL_*   : best-of-three selector codes from heap_cmp3
package heap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic [1:0] SEL_I = 2'd0;
    localparam logic [1:0] SEL_L = 2'd1;
    localparam logic [1:0] SEL_R = 2'd2;

endpackage

// File: rtl/heap_cmp3.sv
// heap_cmp3 -- combinational best-of-three selector for heap sifting.
// Macro HEAP_MIN_EN: defined -> "better" is strictly less (min-heap),
// undefined -> "better" is strictly greater (max-heap).
// Ports:
//   key_i, key_l, key_r : node key and its left/right child keys
//   l_ok, r_ok          : child present (index below current count)
//   sel                 : SEL_I / SEL_L / SEL_R, the winning position
module heap_cmp3 #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] key_i,
    input  logic [DATA_W-1:0] key_l,
    input  logic [DATA_W-1:0] key_r,
    input  logic              l_ok,
    input  logic              r_ok,
    output logic [1:0]        sel
);
    import heap_pkg::*;

    logic [DATA_W-1:0] best_key;

    // Strict comparison: equal keys never displace the incumbent.
    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef HEAP_MIN_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        sel      = SEL_I;
        best_key = key_i;
        if (l_ok && better(key_l, key_i)) begin
            sel      = SEL_L;
            best_key = key_l;
        end
        // Right child must strictly beat the current winner; ties favour the left.
        if (r_ok && better(key_r, best_key)) begin
            sel = SEL_R;
        end
    end

endmodule

// File: rtl/heap_pqueue.sv
// heap_pqueue -- register-array binary-heap priority queue.
// Max-heap by default; macro HEAP_MIN_EN turns it into a min-heap.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : command handshake, in_op 0=push 1=pop, in_data push key
//   out_valid/out_data  : one-cycle pop result
//   top_valid/top_data  : current root (peek), valid only when idle and non-empty
//   count, full, empty  : occupancy
//   err                 : one-cycle strobe on push-when-full or pop-when-empty
module heap_pqueue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              top_valid,
    output logic [DATA_W-1:0] top_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              err
);
    import heap_pkg::*;

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] arr [DEPTH];

    logic              accept, do_push, do_pop;
    logic [ADDR_W-1:0] parent, best, last;
    logic [ADDR_W+1:0] left, right;
    logic              l_ok, r_ok, up_swap, dn_swap;
    logic [1:0]        up_sel, dn_sel;

    logic              we_a, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_a, data_b;

    assign in_ready  = (state == IDLE);
    assign top_valid = (state == IDLE) && !empty;
    assign top_data  = arr[0];

    assign accept  = in_valid && in_ready;
    assign do_push = accept && (in_op == OP_PUSH) && !full;
    assign do_pop  = accept && (in_op == OP_POP) && !empty;

    assign last   = ADDR_W'(count - CNT_ONE);
    assign parent = (idx - ADDR_W'(1)) >> 1;
    // Child indices carry two extra bits so 2i+2 cannot wrap before the range check.
    assign left   = {1'b0, idx, 1'b1};
    assign right  = left + (ADDR_W+2)'(1);
    assign l_ok   = left  < {1'b0, count};
    assign r_ok   = right < {1'b0, count};
    assign best   = (dn_sel == SEL_R) ? right[ADDR_W-1:0] : left[ADDR_W-1:0];

    // Sift-up reuses the selector as a two-way compare: child in the "left" slot.
    heap_cmp3 #(.DATA_W(DATA_W)) u_cmp_up (
        .key_i (arr[parent]),
        .key_l (arr[idx]),
        .key_r (arr[idx]),
        .l_ok  (1'b1),
        .r_ok  (1'b0),
        .sel   (up_sel)
    );

    heap_cmp3 #(.DATA_W(DATA_W)) u_cmp_dn (
        .key_i (arr[idx]),
        .key_l (arr[left[ADDR_W-1:0]]),
        .key_r (arr[right[ADDR_W-1:0]]),
        .l_ok  (l_ok),
        .r_ok  (r_ok),
        .sel   (dn_sel)
    );

    assign up_swap = (state == UP)   && (up_sel == SEL_L);
    assign dn_swap = (state == DOWN) && (dn_sel != SEL_I);

    // Two write ports cover every update: one for push/pop, both for a swap.
    always_comb begin
        we_a   = 1'b0;
        addr_a = '0;
        data_a = '0;
        we_b   = 1'b0;
        addr_b = '0;
        data_b = '0;
        if (do_push) begin
            we_a   = 1'b1;
            addr_a = count[ADDR_W-1:0];
            data_a = in_data;
        end else if (do_pop) begin
            we_a   = 1'b1;
            addr_a = '0;
            data_a = arr[last];
        end else if (up_swap) begin
            we_a   = 1'b1;
            addr_a = idx;
            data_a = arr[parent];
            we_b   = 1'b1;
            addr_b = parent;
            data_b = arr[idx];
        end else if (dn_swap) begin
            we_a   = 1'b1;
            addr_a = idx;
            data_a = arr[best];
            we_b   = 1'b1;
            addr_b = best;
            data_b = arr[idx];
        end
    end

    // NOTE: the key array has no reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (we_a) arr[addr_a] <= data_a;
        if (we_b) arr[addr_b] <= data_b;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_op == OP_PUSH) begin
                            if (full) begin
                                err <= 1'b1;
                            end else begin
                                count <= count + CNT_ONE;
                                full  <= (count == CNT_LAST);
                                empty <= 1'b0;
                                if (count != '0) begin
                                    state <= UP;
                                    idx   <= count[ADDR_W-1:0];
                                end
                            end
                        end else begin
                            if (empty) begin
                                err <= 1'b1;
                            end else begin
                                out_data  <= arr[0];
                                out_valid <= 1'b1;
                                count     <= count - CNT_ONE;
                                full      <= 1'b0;
                                empty     <= (count == CNT_ONE);
                                // Sift-down only needed when at least two entries remain.
                                if (count > CNT_TWO) begin
                                    state <= DOWN;
                                    idx   <= '0;
                                end
                            end
                        end
                    end
                end
                UP: begin
                    // Finishing on the swap into the root keeps UP within ADDR_W cycles.
                    if (up_swap && (parent != '0)) begin
                        idx <= parent;
                    end else begin
                        state <= IDLE;
                    end
                end
                DOWN: begin
                    if (dn_swap) begin
                        idx <= best;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_pqueue.sv
// tb_heap_pqueue -- directed self-checking bench for heap_pqueue (DATA_W=32, DEPTH=8).
// Expected orders follow HEAP_MIN_EN when the bench is built with it defined.
module tb_heap_pqueue;

`ifdef HEAP_MIN_EN
    localparam bit MIN_MODE = 1'b1;
`else
    localparam bit MIN_MODE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        top_valid;
    logic [31:0] top_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic        last_ov;
    logic [31:0] last_od;
    logic        last_er;

    logic [31:0] exp_a [4];

    heap_pqueue #(.DATA_W(32), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .top_valid (top_valid),
        .top_data  (top_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Wait (bounded) until the queue is idle, then confirm it is.
    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(tag, {31'd0, in_ready}, 32'd1);
    endtask

    // One accepted command; result strobes sampled 1 time unit after the accepting edge.
    task automatic issue(input string tag, input logic op, input logic [31:0] d);
        wait_ready(tag);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_ov  = out_valid;
        last_od  = out_data;
        last_er  = err;
    endtask

    task automatic push(input logic [31:0] d);
        issue("ready_push", 1'b0, d);
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        issue("ready_pop", 1'b1, 32'd0);
        check({tag, "_valid"}, {31'd0, last_ov}, 32'd1);
        check(tag, last_od, exp);
        check({tag, "_err"}, {31'd0, last_er}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = 1'b0;
        in_data  = '0;
        if (MIN_MODE) exp_a = '{32'd1, 32'd5, 32'd7, 32'd9};
        else          exp_a = '{32'd9, 32'd7, 32'd5, 32'd1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_top_valid", {31'd0, top_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pop on empty: error strobe, no result
        issue("ready_pop_empty", 1'b1, 32'd0);
        check("pop_empty_err", {31'd0, last_er}, 32'd1);
        check("pop_empty_valid", {31'd0, last_ov}, 32'd0);
        check("pop_empty_count", {28'd0, count}, 32'd0);
        @(posedge clk);
        #1;
        check("pop_empty_err_pulse", {31'd0, err}, 32'd0);

        // Mixed keys
        push(32'd5);
        push(32'd9);
        push(32'd1);
        push(32'd7);
        wait_ready("ready_a");
        check("a_count", {28'd0, count}, 32'd4);
        check("a_top_valid", {31'd0, top_valid}, 32'd1);
        check("a_top", top_data, MIN_MODE ? 32'd1 : 32'd9);
        for (int i = 0; i < 4; i++) pop_expect("a_pop", exp_a[i]);
        wait_ready("ready_a_end");
        check("a_empty", {31'd0, empty}, 32'd1);
        check("a_top_valid_end", {31'd0, top_valid}, 32'd0);

        // Fill to capacity, then overflow
        for (int i = 1; i <= 8; i++) push(i);
        wait_ready("ready_b");
        check("b_full", {31'd0, full}, 32'd1);
        check("b_count", {28'd0, count}, 32'd8);
        check("b_top", top_data, MIN_MODE ? 32'd1 : 32'd8);
        push(32'd100);
        check("b_ovf_err", {31'd0, last_er}, 32'd1);
        check("b_ovf_valid", {31'd0, last_ov}, 32'd0);
        check("b_ovf_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("b_ovf_err_pulse", {31'd0, err}, 32'd0);
        check("b_ovf_count", {28'd0, count}, 32'd8);
        check("b_ovf_top", top_data, MIN_MODE ? 32'd1 : 32'd8);
        check("b_ovf_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 8; i++) pop_expect("b_pop", MIN_MODE ? 32'(i + 1) : 32'(8 - i));
        wait_ready("ready_b_end");
        check("b_empty", {31'd0, empty}, 32'd1);
        check("b_full_end", {31'd0, full}, 32'd0);

        // Equal keys: no swaps, so idle again one cycle after each pop
        for (int i = 0; i < 3; i++) push(32'd3);
        for (int i = 0; i < 3; i++) begin
            issue("ready_c", 1'b1, 32'd0);
            check("c_valid", {31'd0, last_ov}, 32'd1);
            check("c_pop", last_od, 32'd3);
            @(posedge clk);
            #1;
            check("c_ready_1cyc", {31'd0, in_ready}, 32'd1);
        end
        check("c_empty", {31'd0, empty}, 32'd1);

        // Reset during sift-up aborts the operation
        push(32'd1);
        push(32'd2);
        push(32'd3);
        push(32'd4);
        check("d_in_up", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("d_rst_count", {28'd0, count}, 32'd0);
        check("d_rst_ready", {31'd0, in_ready}, 32'd1);
        check("d_rst_empty", {31'd0, empty}, 32'd1);
        check("d_rst_top_valid", {31'd0, top_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(32'd6);
        wait_ready("ready_d");
        check("d_top", top_data, 32'd6);
        check("d_top_valid", {31'd0, top_valid}, 32'd1);
        check("d_count", {28'd0, count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
